// File: rtl/vga_capture.sv
// VGA receive front end: samples sync/valid/RGB, rebuilds (x, y) for a frame-buffer write
// stream, measures active geometry per frame and tracks lock and overflow.
module vga_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        wr_en,
    output logic [9:0]  wr_x,
    output logic [9:0]  wr_y,
    output logic [23:0] wr_data,
    output logic        frame_done,
    output logic [9:0]  meas_width,
    output logic [9:0]  meas_height,
    output logic        locked,
    output logic        err_overflow,
    output logic        dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [3:0] LK    = 4'(LOCK_FRAMES);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_hs_d1, r_vs_d1, r_va_d1;
    logic        r_hs_d2, r_vs_d2, r_va_d2;
    logic [23:0] r_rgb_d1;
    logic [9:0]  r_x_cnt, r_y_cnt;
    logic        r_frame_ovf;
    logic [3:0]  r_lock_cnt;

    logic        r_wr_en, r_frame_done, r_locked, r_err;
    logic [9:0]  r_wr_x, r_wr_y, r_meas_w, r_meas_h;
    logic [23:0] r_wr_data;

    logic        w_hs_fall, w_vs_fall, w_va_fall;
    logic        w_in_range, w_conform;
    logic [9:0]  w_x_inc, w_y_inc;
    logic [3:0]  w_lock_inc;

    assign w_hs_fall  = r_hs_d2 & ~r_hs_d1;
    assign w_vs_fall  = r_vs_d2 & ~r_vs_d1;
    assign w_va_fall  = r_va_d2 & ~r_va_d1;
    assign w_in_range = (r_x_cnt < H_ACT) && (r_y_cnt < V_ACT);
    assign w_x_inc    = (r_x_cnt == 10'h3FF) ? r_x_cnt : r_x_cnt + 10'd1;
    assign w_y_inc    = (r_y_cnt == 10'h3FF) ? r_y_cnt : r_y_cnt + 10'd1;
    // Conformance is judged on the frame that the current vsync fall closes.
    assign w_conform  = (r_meas_w == H_ACT) && (r_y_cnt == V_ACT) && !r_frame_ovf;
    assign w_lock_inc = (r_lock_cnt >= LK) ? LK : r_lock_cnt + 4'd1;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_IDLE && w_vs_fall) w_state_next = S_FRAME;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            // Syncs idle high so release never looks like a falling edge.
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_hs_d2      <= 1'b1;
            r_vs_d2      <= 1'b1;
            r_va_d1      <= 1'b0;
            r_va_d2      <= 1'b0;
            r_rgb_d1     <= '0;
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_frame_ovf  <= 1'b0;
            r_lock_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_meas_w     <= '0;
            r_meas_h     <= '0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_hs_d1      <= hsync;
            r_vs_d1      <= vsync;
            r_va_d1      <= valid;
            r_rgb_d1     <= {vga_r, vga_g, vga_b};
            r_hs_d2      <= r_hs_d1;
            r_vs_d2      <= r_vs_d1;
            r_va_d2      <= r_va_d1;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_vs_fall) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                end
            end else begin
                if (r_va_d1) begin
                    r_wr_x    <= r_x_cnt;
                    r_wr_y    <= r_y_cnt;
                    r_wr_data <= r_rgb_d1;
                    r_x_cnt   <= w_x_inc;
                    if (w_in_range) begin
                        r_wr_en <= 1'b1;
                    end else begin
                        r_err       <= 1'b1;
                        r_frame_ovf <= 1'b1;
                    end
                end
                if (w_va_fall) begin
                    r_meas_w <= r_x_cnt;
                    r_y_cnt  <= w_y_inc;
                end
                // Later assignments take priority over the capture/valid-fall updates above.
                if (w_hs_fall) r_x_cnt <= '0;
                if (w_vs_fall) begin
                    r_y_cnt     <= '0;
                    r_frame_ovf <= 1'b0;
                    if (r_y_cnt != 10'd0) begin
                        r_frame_done <= 1'b1;
                        r_meas_h     <= r_y_cnt;
                        if (w_conform) begin
                            r_lock_cnt <= w_lock_inc;
                            r_locked   <= (w_lock_inc == LK);
                        end else begin
                            r_lock_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_x         = r_wr_x;
    assign wr_y         = r_wr_y;
    assign wr_data      = r_wr_data;
    assign frame_done   = r_frame_done;
    assign meas_width   = r_meas_w;
    assign meas_height  = r_meas_h;
    assign locked       = r_locked;
    assign err_overflow = r_err;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down raster (16x8 active in 24x13 total) so that a
// dozen frames fit in a few thousand cycles; the DUT is parameterised to match.
module tb_vga_capture;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int HT  = 24;
  localparam int VT  = 13;
  localparam int HS0 = 18;
  localparam int HS1 = 21;
  localparam int VS0 = 10;
  localparam int VS1 = 12;
  localparam int W   = 76;  // {cycle[31:0], x[9:0], y[9:0], data[23:0]}
  localparam int FW  = 54;  // {cycle[31:0], height[9:0], width[9:0], locked, err}

  // clock / reset
  logic        pclk = 1'b0;
  logic        reset;
  logic        hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        wr_en, frame_done, locked, err_overflow, dbg_state;
  logic [9:0]  wr_x, wr_y, meas_width, meas_height;
  logic [23:0] wr_data;

  always #20 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
    .locked(locked), .err_overflow(err_overflow), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [FW-1:0] fd_q[$];
  int checks = 0;
  int failures = 0;
  logic armed;
  int rst_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr"}, 64'({wr_x, wr_y, wr_data}), 64'd0);
    chk({tag, "_meas"}, 64'({meas_width, meas_height}), 64'd0);
    chk({tag, "_flags"}, 64'({wr_en, frame_done, locked, err_overflow}), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // driver: one raster frame starting at first_line; expectations are pushed as pixels go out
  task automatic run_frame(input int first_line, input int n_lines, input int long_line,
                           input int rst_line, input bit exp_fd, input logic [9:0] exp_h,
                           input logic exp_lock, input logic exp_err);
    int w;
    for (int v = first_line; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        @(negedge pclk);
        if (v == rst_line && h == 3) begin
          #1;
          reset = 1'b0;
          exp_q.delete();
          fd_q.delete();
          armed = 1'b0;
          rst_hold = 3;
          #1;
          chk_reset_state("midrst");
        end else if (!reset) begin
          if (rst_hold == 0) reset = 1'b1;
          else rst_hold--;
        end
        w = (v == long_line) ? H + 1 : H;
        hsync = !(h >= HS0 && h < HS1);
        vsync = !(v >= VS0 && v < VS1);
        valid = (v < n_lines) && (h < w);
        vga_r = 8'(h);
        vga_g = 8'(v);
        vga_b = 8'hA5;
        if (valid && armed && h < H && v < V)
          exp_q.push_back({32'(cyc + 2), 10'(h), 10'(v), vga_r, vga_g, vga_b});
        if (v == VS0 && h == 0) begin
          if (exp_fd) fd_q.push_back({32'(cyc + 2), exp_h, 10'(H), exp_lock, exp_err});
          if (reset) armed = 1'b1;
        end
      end
    end
  endtask

  // monitor
  logic [W-1:0]  m_e;
  logic [FW-1:0] m_f;
  always @(negedge pclk) begin
    if (exp_q.size() != 0) begin
      m_e = exp_q[0];
      if (!wr_en && m_e[75:44] < 32'(cyc)) begin
        checks++;
        failures++;
        $display("FAIL missed_write x=%0d y=%0d required at cycle %0d", m_e[43:34], m_e[33:24], m_e[75:44]);
        void'(exp_q.pop_front());
      end
    end
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write x=%0d y=%0d data=%06h required none", wr_x, wr_y, wr_data);
      end else begin
        m_e = exp_q.pop_front();
        checks++;
        if (m_e[75:44] != 32'(cyc)) begin
          failures++;
          $display("FAIL write_cycle actual=%0d required=%0d", cyc, m_e[75:44]);
        end
        checks++;
        if ({wr_x, wr_y, wr_data} !== m_e[43:0]) begin
          failures++;
          $display("FAIL write_data actual=%0d,%0d,%06h required=%0d,%0d,%06h",
                   wr_x, wr_y, wr_data, m_e[43:34], m_e[33:24], m_e[23:0]);
        end
      end
    end
    if (fd_q.size() != 0) begin
      m_f = fd_q[0];
      if (!frame_done && m_f[53:22] < 32'(cyc)) begin
        checks++;
        failures++;
        $display("FAIL missed_frame_done actual=0 required=1 at cycle %0d", m_f[53:22]);
        void'(fd_q.pop_front());
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        m_f = fd_q.pop_front();
        checks++;
        if (m_f[53:22] != 32'(cyc)) begin
          failures++;
          $display("FAIL frame_done_cycle actual=%0d required=%0d", cyc, m_f[53:22]);
        end
        checks++;
        if ({meas_height, meas_width} !== m_f[21:2]) begin
          failures++;
          $display("FAIL meas actual=%0dx%0d required=%0dx%0d", meas_width, meas_height, m_f[11:2], m_f[21:12]);
        end
        checks++;
        if (locked !== m_f[1]) begin
          failures++;
          $display("FAIL locked actual=%0b required=%0b", locked, m_f[1]);
        end
        checks++;
        if (err_overflow !== m_f[0]) begin
          failures++;
          $display("FAIL err_overflow actual=%0b required=%0b", err_overflow, m_f[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    valid = 1'b0;
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    armed = 1'b0;
    rst_hold = 3;
    repeat (2) @(negedge pclk);
    #1;
    chk_reset_state("init");
    //        first  lines long rst  fd  height  lock  err
    run_frame(3,     V,    -1,  -1,  0,  10'd0,  1'b0, 1'b0);  // mid-line release, arms only
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b0, 1'b0);
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b1, 1'b0);
    run_frame(0,     V,    2,   -1,  1,  10'd8,  1'b0, 1'b1);  // 17 pixels on line 2
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b0, 1'b1);
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b1, 1'b1);
    run_frame(0,     V-1,  -1,  -1,  1,  10'd7,  1'b0, 1'b1);  // short frame
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b0, 1'b1);
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b1, 1'b1);
    run_frame(0,     V,    -1,  5,   0,  10'd0,  1'b0, 1'b0);  // reset at line 5
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b0, 1'b0);
    run_frame(0,     V,    -1,  -1,  1,  10'd8,  1'b1, 1'b0);
    repeat (8) @(negedge pclk);
    #1;
    chk("wr_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("fd_queue_drained", 64'(fd_q.size()), 64'd0);
    chk("final_locked", 64'(locked), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
